aemb2_dwbif: RTL and testbench

- Data-side Wishbone master for the AEMB2 core.
- Takes the effective address and store operand that the integer unit computes for LXX/SXX instructions and runs one big-endian Wishbone classic cycle per request.
- Returns lane-aligned load data to writeback and holds the pipeline stalled while a transfer is outstanding.
- Flags misaligned accesses and bus timeouts.

---
 rtl/aemb2_dwbif.sv | 177 +++++++++++++++++
 tb/tb_aemb2_dwbif.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb2_dwbif.sv
// AEMB2 data-side Wishbone master.
// Runs one big-endian Wishbone classic cycle per LXX/SXX request, returns
// lane-aligned load data, stalls the pipeline while a transfer is
// outstanding, and flags misaligned accesses and bus timeouts.
module aemb2_dwbif #(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_TMO = 1,
  parameter int AEMB_TMW = 8
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic                  xfer_stb,
  input  logic                  xfer_we,
  input  logic [1:0]            xfer_sz,
  input  logic [31:0]           xfer_adr,
  input  logic [31:0]           xfer_dat,
  input  logic                  xfer_lock,
  output logic                  xfer_busy,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic [31:0]           xfer_rdat,
  output logic [AEMB_DWB-1:2]   dwb_adr_o,
  output logic [3:0]            dwb_sel_o,
  output logic [31:0]           dwb_dat_o,
  output logic                  dwb_we_o,
  output logic                  dwb_stb_o,
  output logic                  dwb_cyc_o,
  input  logic [31:0]           dwb_dat_i,
  input  logic                  dwb_ack_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [AEMB_TMW-1:0] wdog;
  logic [AEMB_TMW-1:0] wdog_nxt;
  logic                misalign;
  logic                req;
  logic                tmo;
  logic [3:0]          sel_nxt;
  logic [31:0]         sdat_nxt;
  logic [31:0]         lane;

  // Request qualification, alignment check and watchdog terminal detect
  always_comb begin
    misalign = ((xfer_sz == 2'b01) && xfer_adr[0]) ||
               (xfer_sz[1] && (xfer_adr[1:0] != 2'b00));
    // the IDLE-entry cycle (done pulse high) never accepts a new request
    req      = xfer_stb && !xfer_done;
    wdog_nxt = wdog + 1'b1;
    // fires on the (2^AEMB_TMW-1)-th unacknowledged ACCESS cycle
    tmo      = (AEMB_TMO != 0) && (&wdog_nxt) && !dwb_ack_i;
  end

  // Big-endian lane selects and store-data replication for the request
  always_comb begin
    sel_nxt  = 4'b1111;
    sdat_nxt = xfer_dat;
    case (xfer_sz)
      2'b00: begin
        sel_nxt  = 4'b1000 >> xfer_adr[1:0];
        sdat_nxt = {4{xfer_dat[7:0]}};
      end
      2'b01: begin
        sel_nxt  = xfer_adr[1] ? 4'b0011 : 4'b1100;
        sdat_nxt = {2{xfer_dat[15:0]}};
      end
      default: begin
        sel_nxt  = 4'b1111;
        sdat_nxt = xfer_dat;
      end
    endcase
  end

  // Load lane extraction keyed off the captured lane selects
  always_comb begin
    lane = dwb_dat_i;
    case (dwb_sel_o)
      4'b1000: lane = {24'h0, dwb_dat_i[31:24]};
      4'b0100: lane = {24'h0, dwb_dat_i[23:16]};
      4'b0010: lane = {24'h0, dwb_dat_i[15:8]};
      4'b0001: lane = {24'h0, dwb_dat_i[7:0]};
      4'b1100: lane = {16'h0, dwb_dat_i[31:16]};
      4'b0011: lane = {16'h0, dwb_dat_i[15:0]};
      default: lane = dwb_dat_i;
    endcase
  end

  // Next-state logic and combinational stall
  always_comb begin
    state_nxt = state;
    xfer_busy = 1'b1;
    case (state)
      IDLE: begin
        xfer_busy = xfer_stb;
        if (req) state_nxt = misalign ? FAULT : ACCESS;
      end
      ACCESS: begin
        if (dwb_ack_i || tmo) state_nxt = IDLE;
      end
      FAULT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs, completion pulses, load data and watchdog
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      xfer_rdat <= '0;
      dwb_adr_o <= '0;
      dwb_sel_o <= '0;
      dwb_dat_o <= '0;
      dwb_we_o  <= 1'b0;
      dwb_stb_o <= 1'b0;
      dwb_cyc_o <= 1'b0;
      wdog      <= '0;
    end else begin
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !misalign) begin
            dwb_stb_o <= 1'b1;
            dwb_cyc_o <= 1'b1;
            dwb_adr_o <= xfer_adr[AEMB_DWB-1:2];
            dwb_sel_o <= sel_nxt;
            dwb_dat_o <= sdat_nxt;
            dwb_we_o  <= xfer_we;
            wdog      <= '0;
          end else if (req) begin
            xfer_done <= 1'b1;
            xfer_err  <= 1'b1;
          end else if (!xfer_lock) begin
            dwb_cyc_o <= 1'b0;
          end
        end
        ACCESS: begin
          if (dwb_ack_i) begin
            dwb_stb_o <= 1'b0;
            if (!xfer_lock) dwb_cyc_o <= 1'b0;
            xfer_done <= 1'b1;
            if (!dwb_we_o) xfer_rdat <= lane;
          end else if (tmo) begin
            // a timeout releases the bus even under lock
            dwb_stb_o <= 1'b0;
            dwb_cyc_o <= 1'b0;
            xfer_done <= 1'b1;
            xfer_err  <= 1'b1;
            xfer_rdat <= '0;
          end else begin
            wdog <= wdog_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb2_dwbif.sv
// Self-checking bench for aemb2_dwbif: directed scenarios plus randomized
// transfers against a behavioural model of the data-side bus interface.
module tb_aemb2_dwbif;

  localparam int TMW = 4;

  logic        gclk = 1'b0;
  logic        grst = 1'b0;
  logic        xfer_stb = 1'b0;
  logic        xfer_we = 1'b0;
  logic [1:0]  xfer_sz = 2'b00;
  logic [31:0] xfer_adr = '0;
  logic [31:0] xfer_dat = '0;
  logic        xfer_lock = 1'b0;
  logic        xfer_busy;
  logic        xfer_done;
  logic        xfer_err;
  logic [31:0] xfer_rdat;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic [31:0] dwb_dat_o;
  logic        dwb_we_o;
  logic        dwb_stb_o;
  logic        dwb_cyc_o;
  logic [31:0] dwb_dat_i = '0;
  logic        dwb_ack_i;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdat = '0;

  // slave model: acks after slv_wait wait states when enabled
  logic [7:0]  wcnt;
  int          slv_wait = 0;
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;

  assign dwb_ack_i = force_ack | (dwb_stb_o & ack_en & (int'(wcnt) == slv_wait));

  always @(posedge gclk or negedge grst) begin
    if (!grst) wcnt <= '0;
    else       wcnt <= (dwb_stb_o && !dwb_ack_i) ? wcnt + 8'd1 : 8'd0;
  end

  always #5 gclk = ~gclk;

  aemb2_dwbif #(.AEMB_DWB(32), .AEMB_TMO(1), .AEMB_TMW(TMW)) dut (
    .gclk(gclk), .grst(grst),
    .xfer_stb(xfer_stb), .xfer_we(xfer_we), .xfer_sz(xfer_sz),
    .xfer_adr(xfer_adr), .xfer_dat(xfer_dat), .xfer_lock(xfer_lock),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .xfer_rdat(xfer_rdat),
    .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o),
    .dwb_we_o(dwb_we_o), .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o),
    .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] adr);
    int off = int'(adr % 4);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] adr);
    int off = int'(adr % 4);
    if (sz == 2'd0) return 4'(1 << (3 - off));
    if (sz == 2'd1) return (off >= 2) ? 4'h3 : 4'hC;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdat(input logic [1:0] sz, input logic [31:0] adr, input logic [31:0] d);
    int off = int'(adr % 4);
    if (sz == 2'd0) return (d >> (8 * (3 - off))) % 256;
    if (sz == 2'd1) return (d >> ((off >= 2) ? 0 : 16)) % 65536;
    return d;
  endfunction

  // one request from a negedge in IDLE through the cycle after completion
  task automatic xfer(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                      input logic [31:0] dat, input int waits, input logic ackon,
                      input logic lock, input logic [31:0] rdata);
    bit          mis = m_mis(sz, adr);
    bit          tmo = !ackon || (waits >= 15);
    int          n;
    int          stb_cycles;
    int          exp_stb;
    logic [3:0]  esel = m_sel(sz, adr);
    logic [31:0] edat = m_wdat(sz, dat);
    slv_wait  = waits;
    ack_en    = ackon;
    dwb_dat_i = rdata;
    xfer_stb  = 1'b1;
    xfer_we   = we;
    xfer_sz   = sz;
    xfer_adr  = adr;
    xfer_dat  = dat;
    xfer_lock = lock;
    #1 chk("busy_req", 32'(xfer_busy), 32'd1);
    @(negedge gclk);
    if (mis) begin
      chk("fault_done", 32'(xfer_done), 32'd1);
      chk("fault_err", 32'(xfer_err), 32'd1);
      chk("fault_busy", 32'(xfer_busy), 32'd1);
      chk("fault_stb", 32'(dwb_stb_o), 32'd0);
      xfer_stb = 1'b0;
      @(negedge gclk);
      chk("fault_end_done", 32'(xfer_done), 32'd0);
      chk("fault_end_busy", 32'(xfer_busy), 32'd0);
      chk("fault_rdat", xfer_rdat, exp_rdat);
      return;
    end
    chk("acc_stb", 32'(dwb_stb_o), 32'd1);
    chk("acc_cyc", 32'(dwb_cyc_o), 32'd1);
    chk("acc_adr", 32'(dwb_adr_o), adr >> 2);
    chk("acc_sel", 32'(esel), 32'(dwb_sel_o) & 32'hF | 32'(esel) & 32'h0 | 32'(esel) & 32'h0);
    chk("acc_dat", dwb_dat_o, edat);
    chk("acc_we", 32'(dwb_we_o), 32'(we));
    // inputs while busy must be ignored
    xfer_stb = 1'b0;
    xfer_adr = $urandom;
    xfer_dat = $urandom;
    xfer_we  = ~we;
    xfer_sz  = 2'($urandom_range(0, 3));
    n = 1;
    stb_cycles = 0;
    while (xfer_done !== 1'b1 && n < 40) begin
      if (dwb_stb_o) stb_cycles++;
      chk("wait_busy", 32'(xfer_busy), 32'd1);
      @(negedge gclk);
      n++;
    end
    exp_stb = tmo ? 15 : waits + 1;
    if (!we || tmo) exp_rdat = tmo ? 32'd0 : m_rdat(sz, adr, rdata);
    chk("latency", 32'(n), 32'(exp_stb + 1));
    chk("stb_cycles", 32'(stb_cycles), 32'(exp_stb));
    chk("done", 32'(xfer_done), 32'd1);
    chk("err", 32'(xfer_err), 32'(tmo));
    chk("done_stb", 32'(dwb_stb_o), 32'd0);
    chk("done_cyc", 32'(dwb_cyc_o), tmo ? 32'd0 : 32'(lock));
    chk("rdat", xfer_rdat, exp_rdat);
    chk("hold_adr", 32'(dwb_adr_o), adr >> 2);
    chk("hold_dat", dwb_dat_o, edat);
    chk("hold_we", 32'(dwb_we_o), 32'(we));
    @(negedge gclk);
    chk("post_done", 32'(xfer_done), 32'd0);
    chk("post_err", 32'(xfer_err), 32'd0);
    chk("post_stb", 32'(dwb_stb_o), 32'd0);
  endtask

  logic [3:0] pat_stb;
  logic [5:0] exp_stbp;
  logic [5:0] exp_donep;

  initial begin
    // reset state
    #12;
    chk("rst_stb", 32'(dwb_stb_o), 32'd0);
    chk("rst_cyc", 32'(dwb_cyc_o), 32'd0);
    chk("rst_done", 32'(xfer_done), 32'd0);
    chk("rst_err", 32'(xfer_err), 32'd0);
    chk("rst_rdat", xfer_rdat, 32'd0);
    chk("rst_adr", 32'(dwb_adr_o), 32'd0);
    chk("rst_sel", 32'(dwb_sel_o), 32'd0);
    chk("rst_busy", 32'(xfer_busy), 32'd0);
    @(negedge gclk);
    grst = 1'b1;
    @(negedge gclk);

    // directed scenarios
    xfer(1'b0, 2'd2, 32'h0000_1004, 32'h0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("wl_adr", 32'(dwb_adr_o), 32'h401);
    chk("wl_sel", 32'(dwb_sel_o), 32'hF);
    xfer(1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5, 0, 1'b1, 1'b0, 32'h0);
    chk("bs_sel", 32'(dwb_sel_o), 32'h1);
    chk("bs_dat", dwb_dat_o, 32'hA5A5_A5A5);
    xfer(1'b0, 2'd0, 32'h0000_2001, 32'h0, 0, 1'b1, 1'b0, 32'h1122_3344);
    chk("bl_rdat", xfer_rdat, 32'h22);
    xfer(1'b0, 2'd1, 32'h0000_3002, 32'h0, 3, 1'b1, 1'b0, 32'hCAFE_BABE);
    chk("hl_rdat", xfer_rdat, 32'h0000_BABE);
    xfer(1'b0, 2'd2, 32'h0000_4002, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    xfer(1'b0, 2'd1, 32'h0000_4003, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    xfer(1'b0, 2'd3, 32'h0000_4001, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    xfer(1'b1, 2'd2, 32'h0000_5000, 32'h1234_5678, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    xfer(1'b0, 2'd2, 32'h0000_5004, 32'h0, 14, 1'b1, 1'b0, 32'h5555_AAAA);

    // locked pair: cyc stays up between accesses
    xfer(1'b0, 2'd2, 32'h0000_6000, 32'h0, 0, 1'b1, 1'b1, 32'h0102_0304);
    chk("lock_gap_cyc", 32'(dwb_cyc_o), 32'd1);
    chk("lock_gap_stb", 32'(dwb_stb_o), 32'd0);
    xfer(1'b0, 2'd2, 32'h0000_6004, 32'h0, 1, 1'b1, 1'b1, 32'h0506_0708);
    chk("lock_gap2_cyc", 32'(dwb_cyc_o), 32'd1);
    xfer_lock = 1'b0;
    @(negedge gclk);
    chk("unlock_cyc", 32'(dwb_cyc_o), 32'd0);

    // held request: done cycle is never an accept cycle
    slv_wait = 0; ack_en = 1'b1; dwb_dat_i = 32'h0;
    xfer_stb = 1'b1; xfer_we = 1'b0; xfer_sz = 2'd2; xfer_adr = 32'h0000_7000;
    exp_stbp  = 6'b100100;
    exp_donep = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      @(negedge gclk);
      if (i == 5) xfer_stb = 1'b0;
      chk("b2b_stb", 32'(dwb_stb_o), 32'(exp_stbp[5-i]));
      chk("b2b_done", 32'(xfer_done), 32'(exp_donep[5-i]));
    end
    exp_rdat = 32'h0;
    @(negedge gclk);

    // stray ack in IDLE has no effect
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk);
      chk("stray_done", 32'(xfer_done), 32'd0);
      chk("stray_stb", 32'(dwb_stb_o), 32'd0);
    end
    force_ack = 1'b0;
    @(negedge gclk);

    // randomized transfers
    for (int i = 0; i < 30; i++) begin
      xfer(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
           int'($urandom_range(0, 3)), 1'b1, 1'b0, $urandom);
    end

    // reset in the middle of an access
    xfer_stb = 1'b1; xfer_we = 1'b0; xfer_sz = 2'd2; xfer_adr = 32'h0000_8000;
    ack_en = 1'b0;
    @(negedge gclk);
    xfer_stb = 1'b0;
    chk("mid_stb", 32'(dwb_stb_o), 32'd1);
    #2 grst = 1'b0;
    #1;
    chk("arst_stb", 32'(dwb_stb_o), 32'd0);
    chk("arst_cyc", 32'(dwb_cyc_o), 32'd0);
    chk("arst_done", 32'(xfer_done), 32'd0);
    @(negedge gclk);
    chk("arst_done2", 32'(xfer_done), 32'd0);
    chk("arst_busy", 32'(xfer_busy), 32'd0);
    grst = 1'b1;
    @(negedge gclk);
    chk("arst_idle_stb", 32'(dwb_stb_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
